axil_reg_slave: RTL and testbench



---
 rtl/axil_reg_slave_if.sv | 36 +++
 rtl/axil_reg_slave.sv | 132 +++++++++++++
 tb/tb_axil_reg_slave.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle connecting a master to axil_reg_slave.
// Carries the five channels: AW (awaddr/awvalid/awready), W (wdata/wstrb/
// wvalid/wready), B (bresp/bvalid/bready), AR (araddr/arvalid/arready) and
// R (rdata/rresp/rvalid/rready).
interface axil_reg_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave register bank of NUM_REGS DATA_WIDTH-bit registers.
// Ports: aclk (rising-edge clock), aresetn (async active-low reset),
// bus (axil_reg_slave_if.slave: AW/W/B/AR/R channels). All outputs registered.
// Out-of-range accesses answer SLVERR with no register update / zero read data.
module axil_reg_slave #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic              aclk,
  input logic              aresetn,
  axil_reg_slave_if.slave  bus
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  awready_q, wready_q, arready_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  aw_hs_c, w_hs_c, ar_hs_c;
  logic                  commit_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [STRB_W-1:0]     wr_strb_c;
  logic                  wr_ok_c, rd_ok_c;
  logic [IDX_W-1:0]      wr_idx_c, rd_idx_c;
  logic                  aw_held_d, w_held_d, bvalid_d, rvalid_d;

  // Address lies inside the bank (low byte-lane bits ignored).
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> (LSB + IDX_W)) == '0);
  endfunction

  // Word index of an address within the bank.
  function automatic logic [IDX_W-1:0] reg_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off[LSB +: IDX_W];
  endfunction

  // Handshakes, commit decision and next-cycle ready/valid values.
  always_comb begin
    aw_hs_c   = bus.awvalid & awready_q;
    w_hs_c    = bus.wvalid & wready_q;
    ar_hs_c   = bus.arvalid & arready_q;
    // Commit as soon as both halves are available, using the fresh beat if
    // it is being accepted this edge, otherwise the held copy.
    commit_c  = (aw_held_q | aw_hs_c) & (w_held_q | w_hs_c);
    wr_addr_c = aw_hs_c ? bus.awaddr : aw_addr_q;
    wr_data_c = w_hs_c ? bus.wdata : w_data_q;
    wr_strb_c = w_hs_c ? bus.wstrb : w_strb_q;
    wr_ok_c   = in_range(wr_addr_c);
    wr_idx_c  = reg_idx(wr_addr_c);
    rd_ok_c   = in_range(bus.araddr);
    rd_idx_c  = reg_idx(bus.araddr);
    aw_held_d = ~commit_c & (aw_held_q | aw_hs_c);
    w_held_d  = ~commit_c & (w_held_q | w_hs_c);
    bvalid_d  = commit_c | (bvalid_q & ~bus.bready);
    rvalid_d  = ar_hs_c | (rvalid_q & ~bus.rready);
  end

  // State, response and register-array update.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      regs      <= '{default: '0};
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      awready_q <= ~aw_held_d & ~bvalid_d;
      wready_q  <= ~w_held_d & ~bvalid_d;
      arready_q <= ~rvalid_d;
      if (aw_hs_c) aw_addr_q <= bus.awaddr;
      if (w_hs_c) begin
        w_data_q <= bus.wdata;
        w_strb_q <= bus.wstrb;
      end
      if (commit_c) begin
        bresp_q <= wr_ok_c ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok_c) begin
          for (int b = 0; b < int'(STRB_W); b++) begin
            if (wr_strb_c[b]) regs[wr_idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
          end
        end
      end
      // Sampled before this edge's write lands: same-edge read sees old data.
      if (ar_hs_c) begin
        rdata_q <= rd_ok_c ? regs[rd_idx_c] : '0;
        rresp_q <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.arready = arready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed self-checking bench for axil_reg_slave (32-bit data, 16 regs, base 0).
module tb_axil_reg_slave;

  logic aclk;
  logic aresetn;
  int   checks;
  int   errors;

  axil_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_reg_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS  (16),
    .BASE_ADDR (32'h0)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".awready"}, 32'(bus.awready), 0);
    chk({tag, ".wready"},  32'(bus.wready),  0);
    chk({tag, ".arready"}, 32'(bus.arready), 0);
    chk({tag, ".bvalid"},  32'(bus.bvalid),  0);
    chk({tag, ".bresp"},   32'(bus.bresp),   0);
    chk({tag, ".rvalid"},  32'(bus.rvalid),  0);
    chk({tag, ".rresp"},   32'(bus.rresp),   0);
    chk({tag, ".rdata"},   bus.rdata,        0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    chk({tag, ".arready_pre"}, 32'(bus.arready), 1);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    step();
    bus.arvalid = 1'b0;
    chk({tag, ".rvalid"},  32'(bus.rvalid), 1);
    chk({tag, ".rdata"},   bus.rdata, exp_data);
    chk({tag, ".rresp"},   32'(bus.rresp), 32'(exp_resp));
    chk({tag, ".arready_busy"}, 32'(bus.arready), 0);
    bus.rready = 1'b1;
    step();
    bus.rready = 1'b0;
    chk({tag, ".rvalid_done"}, 32'(bus.rvalid), 0);
    chk({tag, ".arready_post"}, 32'(bus.arready), 1);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.wvalid  = 1'b1;
    step();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    chk({tag, ".bvalid"},  32'(bus.bvalid), 1);
    chk({tag, ".bresp"},   32'(bus.bresp), 32'(exp_resp));
    chk({tag, ".awready_busy"}, 32'(bus.awready), 0);
    chk({tag, ".wready_busy"},  32'(bus.wready), 0);
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    chk({tag, ".bvalid_done"}, 32'(bus.bvalid), 0);
    chk({tag, ".awready_post"}, 32'(bus.awready), 1);
    chk({tag, ".wready_post"},  32'(bus.wready), 1);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    aresetn     = 1'b0;
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;

    // Reset release.
    step();
    step();
    chk_reset_outputs("in_reset");
    aresetn = 1'b1;
    chk("pre_edge.awready", 32'(bus.awready), 0);
    step();
    chk("release.awready", 32'(bus.awready), 1);
    chk("release.wready",  32'(bus.wready),  1);
    chk("release.arready", 32'(bus.arready), 1);
    do_read("rd_reg3_reset", 32'h0C, 32'h0000_0000, 2'b00);

    // Simultaneous AW+W full write, then read back.
    do_write("wr_deadbeef", 32'h08, 32'hDEAD_BEEF, 4'hF, 2'b00);
    do_read("rd_deadbeef", 32'h08, 32'hDEAD_BEEF, 2'b00);

    // W three cycles ahead of AW, partial strobes.
    bus.wdata  = 32'h1122_3344;
    bus.wstrb  = 4'b0101;
    bus.wvalid = 1'b1;
    step();
    bus.wvalid = 1'b0;
    chk("wfirst.wready_held", 32'(bus.wready), 0);
    chk("wfirst.awready",     32'(bus.awready), 1);
    chk("wfirst.bvalid0",     32'(bus.bvalid), 0);
    step();
    step();
    chk("wfirst.bvalid_wait", 32'(bus.bvalid), 0);
    chk("wfirst.wready_wait", 32'(bus.wready), 0);
    bus.awaddr  = 32'h08;
    bus.awvalid = 1'b1;
    step();
    bus.awvalid = 1'b0;
    chk("wfirst.bvalid", 32'(bus.bvalid), 1);
    chk("wfirst.bresp",  32'(bus.bresp), 0);
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    chk("wfirst.bvalid_done", 32'(bus.bvalid), 0);
    do_read("rd_merged", 32'h08, 32'hDE22_BE44, 2'b00);
    do_read("rd_unaligned", 32'h0B, 32'hDE22_BE44, 2'b00);

    // Zero strobes in range: OKAY, no change.
    do_write("wr_strb0", 32'h08, 32'hFFFF_FFFF, 4'h0, 2'b00);
    do_read("rd_strb0", 32'h08, 32'hDE22_BE44, 2'b00);

    // Out of range.
    do_write("wr_oor", 32'h40, 32'hFFFF_FFFF, 4'hF, 2'b10);
    do_read("rd_oor", 32'h40, 32'h0000_0000, 2'b10);
    do_read("rd_reg0_after_oor", 32'h00, 32'h0000_0000, 2'b00);
    do_read("rd_reg8_after_oor", 32'h08, 32'hDE22_BE44, 2'b00);
    do_read("rd_reg15_after_oor", 32'h3C, 32'h0000_0000, 2'b00);

    // Backpressure with same-edge write and read of register 1.
    bus.awaddr  = 32'h04;
    bus.awvalid = 1'b1;
    bus.wdata   = 32'hA5A5_5A5A;
    bus.wstrb   = 4'hF;
    bus.wvalid  = 1'b1;
    bus.araddr  = 32'h04;
    bus.arvalid = 1'b1;
    step();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp.bvalid",  32'(bus.bvalid), 1);
      chk("bp.bresp",   32'(bus.bresp), 0);
      chk("bp.rvalid",  32'(bus.rvalid), 1);
      chk("bp.rdata",   bus.rdata, 32'h0000_0000);
      chk("bp.rresp",   32'(bus.rresp), 0);
      chk("bp.awready", 32'(bus.awready), 0);
      chk("bp.wready",  32'(bus.wready), 0);
      chk("bp.arready", 32'(bus.arready), 0);
      step();
    end
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    step();
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    chk("bp.bvalid_done", 32'(bus.bvalid), 0);
    chk("bp.rvalid_done", 32'(bus.rvalid), 0);
    chk("bp.awready_back", 32'(bus.awready), 1);
    chk("bp.wready_back",  32'(bus.wready), 1);
    chk("bp.arready_back", 32'(bus.arready), 1);
    do_read("rd_reg1", 32'h04, 32'hA5A5_5A5A, 2'b00);

    // Reset while AW is held and R is pending.
    bus.awaddr  = 32'h08;
    bus.awvalid = 1'b1;
    bus.araddr  = 32'h08;
    bus.arvalid = 1'b1;
    step();
    bus.awvalid = 1'b0;
    bus.arvalid = 1'b0;
    chk("mid.rvalid_pending", 32'(bus.rvalid), 1);
    chk("mid.awready_held",   32'(bus.awready), 0);
    aresetn = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    step();
    aresetn = 1'b1;
    step();
    chk("post.awready", 32'(bus.awready), 1);
    chk("post.wready",  32'(bus.wready), 1);
    chk("post.rvalid",  32'(bus.rvalid), 0);
    // A lone W must not commit against a discarded AW.
    bus.wdata  = 32'hFFFF_FFFF;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    step();
    bus.wvalid = 1'b0;
    step();
    chk("post.no_stale_b", 32'(bus.bvalid), 0);
    chk("post.no_stale_r", 32'(bus.rvalid), 0);
    bus.awaddr  = 32'h3C;
    bus.awvalid = 1'b1;
    step();
    bus.awvalid = 1'b0;
    chk("post.w_commit_bvalid", 32'(bus.bvalid), 1);
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    do_read("rd_reg8_post_reset", 32'h08, 32'h0000_0000, 2'b00);
    do_read("rd_reg1_post_reset", 32'h04, 32'h0000_0000, 2'b00);
    do_read("rd_reg15_new", 32'h3C, 32'hFFFF_FFFF, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
